alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle control sequencer on the issuing side of the ALU control interface.
- Accepts one 19-bit instruction at a time from the fetch stage over a valid/ready handshake and decodes it.
- Drives ALU mode/operation, register-file addresses, the immediate operand and the write-enable.
- Latches the ALU zero/sign flags into a status register and resolves conditional branches from those latched flags.

Parameters:
- WORD_SIZE, 19, datapath and instruction width.
- ADDR_WIDTH, 11, program-counter / branch-target width.
- RF_ADDR_W, 3, register-file address width (8 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  WORD_SIZE  instruction; bits [18:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [7:0] imm8, [10:0] branch target.
- instr_valid  in  1  fetch has an instruction.
- instr_ready  out  1  sequencer can accept an instruction.
- alu_zero  in  1  ALU result == 0.
- alu_sign  in  1  ALU result bit [WORD_SIZE-1].
- alu_mode  out  1  0 = arithmetic, 1 = logical.
- alu_op  out  4  operation select within the mode.
- src_imm  out  1  operand_2 taken from imm_out instead of rs2.
- imm_out  out  WORD_SIZE  imm8 sign-extended.
- rs1_addr, rs2_addr, rd_addr  out  RF_ADDR_W each  register-file addresses.
- rf_we  out  1  one-cycle register write strobe.
- pc_load  out  1  one-cycle branch-taken strobe.
- pc_target  out  ADDR_WIDTH  branch target.
- flag_z, flag_n  out  1 each  latched status flags.
- illegal  out  1  one-cycle illegal-opcode pulse.
- halted  out  1  sequencer is stopped.

Behaviour:
- Reset: all outputs 0, state IDLE, instruction register cleared.
- instr_ready = 1 only in IDLE.
- Opcodes:
  - Arithmetic: 0x01 ADD, 0x02 SUB, 0x03 INC, 0x04 DEC, 0x05 CMP. alu_mode=0; alu_op = opcode[3:0].
  - Logical: 0x08 AND, 0x09 OR, 0x0A XOR, 0x0B NOT, 0x0C SHL, 0x0D SHR. alu_mode=1; alu_op = opcode[3:0].
  - 0x10 ADDI: arithmetic ADD with src_imm=1.
  - Control: 0x00 NOP, 0x18 JMP, 0x19 JZ, 0x1A JNZ, 0x1B JN, 0x1F HALT.
  - Any other opcode is illegal.
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK, BRANCH, HALTED.
- IDLE: on instr_valid && instr_ready, capture instr and go to DECODE (accept edge = cycle 0).
- DECODE (cycle 1):
  - rs1/rs2/rd addresses become valid.
  - ALU/ADDI → EXECUTE.
  - Branch → BRANCH.
  - NOP → IDLE.
  - HALT → HALTED.
  - Illegal → IDLE with illegal=1 for this cycle only; no flag or register change.
- EXECUTE (cycle 2): alu_mode, alu_op, src_imm and imm_out held stable; alu_zero/alu_sign sampled at the end of the cycle.
- WRITEBACK (cycle 3):
  - flag_z/flag_n updated from the sampled values.
  - rf_we=1 with rd_addr, except CMP (flags only, rf_we=0).
  - Next state IDLE; instr_ready=1 at cycle 4.
- BRANCH (cycle 2):
  - pc_target = instr[10:0].
  - pc_load=1 if JMP, JZ with flag_z=1, JNZ with flag_z=0, or JN with flag_n=1; otherwise 0.
  - Flags unchanged. Next state IDLE.
- HALTED: halted=1 and instr_ready=0 until reset; instr_valid is ignored.
- Flags are set only in WRITEBACK and persist across branches, NOPs and illegal instructions.
- ALU control outputs hold their last values outside EXECUTE; rf_we, pc_load and illegal are single-cycle strobes.
- instr_valid deasserting outside IDLE has no effect; the captured instruction completes.
- Reset asserted in any state clears everything asynchronously; an in-flight instruction is dropped with no rf_we or pc_load.

Optional Feature:
- Macro SEQ_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt (16 bits), reset to 0.
  - Increments by 1 on each WRITEBACK and each BRANCH state, taken or not; wraps 0xFFFF→0.
  - NOP, HALT and illegal instructions do not count.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ADD rd=3, rs1=1, rs2=2 accepted at cycle 0; ALU returns zero=0, sign=0 → alu_mode=0 and alu_op=1 at cycle 2; rf_we=1 with rd_addr=3 at cycle 3; flag_z=0; instr_ready=1 at cycle 4.
- SUB with alu_zero=1, then JZ target 0x155 → flag_z=1 after WRITEBACK; pc_load=1 with pc_target=0x155 two cycles after the JZ accept. Repeat with JNZ → pc_load stays 0.
- ADDI imm8=0xF0 → src_imm=1, imm_out=0x7FFF0 in EXECUTE; CMP with alu_sign=1 → flag_n=1, rf_we=0; a following JN branches.
- Opcode 0x07 → illegal=1 for exactly one cycle at cycle 1; flags and rf_we unchanged; ready again at cycle 2.
- HALT, then instr_valid held at 1 for 20 cycles → halted=1, instr_ready=0 throughout; pulsing rst_n low returns to IDLE with all outputs 0.
- rst_n asserted during the EXECUTE of an ADD → no rf_we, flags stay 0. With SEQ_RETIRE_CNT_EN defined: 3 ALU ops, 1 NOP and 2 branches → retire_cnt=5.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU control sequencer with latched flags and branch resolution
// Optional retire counter output enabled by defining SEQ_RETIRE_CNT_EN.
module alu_op_sequencer #(
    parameter int WORD_SIZE  = 19,
    parameter int ADDR_WIDTH = 11,
    parameter int RF_ADDR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_SIZE-1:0]  instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  alu_zero,
    input  logic                  alu_sign,
    output logic                  alu_mode,
    output logic [3:0]            alu_op,
    output logic                  src_imm,
    output logic [WORD_SIZE-1:0]  imm_out,
    output logic [RF_ADDR_W-1:0]  rs1_addr,
    output logic [RF_ADDR_W-1:0]  rs2_addr,
    output logic [RF_ADDR_W-1:0]  rd_addr,
    output logic                  rf_we,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  illegal,
    output logic                  halted
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]           retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK, S_BRANCH, S_HALTED
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_CMP  = 5'h05;
    localparam logic [4:0] OP_ADDI = 5'h10;
    localparam logic [4:0] OP_JMP  = 5'h18;
    localparam logic [4:0] OP_JZ   = 5'h19;
    localparam logic [4:0] OP_JNZ  = 5'h1A;
    localparam logic [4:0] OP_JN   = 5'h1B;
    localparam logic [4:0] OP_HALT = 5'h1F;

    state_t                r_state;
    logic [WORD_SIZE-1:0]  r_instr;
    logic                  r_ready;
    logic                  r_alu_mode;
    logic [3:0]            r_alu_op;
    logic                  r_src_imm;
    logic [WORD_SIZE-1:0]  r_imm;
    logic                  r_rf_we;
    logic                  r_pc_load;
    logic [ADDR_WIDTH-1:0] r_pc_target;
    logic                  r_flag_z;
    logic                  r_flag_n;
    logic                  r_illegal;
    logic                  r_halted;

    logic [4:0]            w_op;
    logic [4:0]            w_in_op;
    logic                  w_taken;

    function automatic logic f_is_alu(input logic [4:0] op);
        return (op >= 5'h01 && op <= 5'h05) || (op >= 5'h08 && op <= 5'h0D) || (op == OP_ADDI);
    endfunction

    function automatic logic f_is_branch(input logic [4:0] op);
        return (op >= OP_JMP) && (op <= OP_JN);
    endfunction

    function automatic logic f_is_legal(input logic [4:0] op);
        return f_is_alu(op) || f_is_branch(op) || (op == OP_NOP) || (op == OP_HALT);
    endfunction

    assign w_op    = r_instr[WORD_SIZE-1 -: 5];
    assign w_in_op = instr[WORD_SIZE-1 -: 5];
    assign w_taken = (w_op == OP_JMP) || (w_op == OP_JZ && r_flag_z) ||
                     (w_op == OP_JNZ && !r_flag_z) || (w_op == OP_JN && r_flag_n);

    // Register addresses come straight from the instruction register so they are valid from DECODE on.
    assign rs1_addr    = r_instr[8 +: RF_ADDR_W];
    assign rs2_addr    = r_instr[5 +: RF_ADDR_W];
    assign rd_addr     = r_instr[11 +: RF_ADDR_W];
    assign instr_ready = r_ready;
    assign alu_mode    = r_alu_mode;
    assign alu_op      = r_alu_op;
    assign src_imm     = r_src_imm;
    assign imm_out     = r_imm;
    assign rf_we       = r_rf_we;
    assign pc_load     = r_pc_load;
    assign pc_target   = r_pc_target;
    assign flag_z      = r_flag_z;
    assign flag_n      = r_flag_n;
    assign illegal     = r_illegal;
    assign halted      = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_ready     <= 1'b0;
            r_alu_mode  <= 1'b0;
            r_alu_op    <= '0;
            r_src_imm   <= 1'b0;
            r_imm       <= '0;
            r_rf_we     <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_target <= '0;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_illegal   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_rf_we   <= 1'b0;
            r_pc_load <= 1'b0;
            r_illegal <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_instr   <= instr;
                        r_ready   <= 1'b0;
                        r_illegal <= !f_is_legal(w_in_op);
                        r_state   <= S_DECODE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (f_is_alu(w_op)) begin
                        r_alu_mode <= (w_op[4:3] == 2'b01);
                        r_alu_op   <= (w_op == OP_ADDI) ? 4'h1 : w_op[3:0];
                        r_src_imm  <= (w_op == OP_ADDI);
                        r_imm      <= {{(WORD_SIZE-8){r_instr[7]}}, r_instr[7:0]};
                        r_state    <= S_EXECUTE;
                    end else if (f_is_branch(w_op)) begin
                        r_pc_target <= r_instr[ADDR_WIDTH-1:0];
                        r_pc_load   <= w_taken;
                        r_state     <= S_BRANCH;
                    end else if (w_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALTED;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_EXECUTE: begin
                    r_flag_z <= alu_zero;
                    r_flag_n <= alu_sign;
                    r_rf_we  <= (w_op != OP_CMP);
                    r_state  <= S_WRITEBACK;
                end
                S_WRITEBACK, S_BRANCH: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_retire_cnt <= '0;
        else if (r_state == S_WRITEBACK || r_state == S_BRANCH)
            r_retire_cnt <= r_retire_cnt + 16'd1;
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [18:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        alu_zero = 1'b0;
    logic        alu_sign = 1'b0;
    logic        alu_mode;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic [18:0] imm_out;
    logic [2:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rf_we, pc_load;
    logic [10:0] pc_target;
    logic        flag_z, flag_n, illegal, halted;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // Per-cycle observations after an accept (index = cycle number)
    logic        obs_ready [1:5];
    logic        obs_rf_we [1:5];
    logic        obs_pc_load [1:5];
    logic        obs_illegal [1:5];
    logic        obs_mode [1:5];
    logic [3:0]  obs_op [1:5];
    logic        obs_src [1:5];
    logic [18:0] obs_imm [1:5];
    logic [2:0]  obs_rs1 [1:5];
    logic [2:0]  obs_rs2 [1:5];
    logic [2:0]  obs_rd [1:5];
    logic [10:0] obs_target [1:5];
    logic        obs_fz [1:5];
    logic        obs_fn [1:5];
    logic        obs_halted [1:5];

    bit m_z = 0, m_n = 0;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .alu_mode(alu_mode), .alu_op(alu_op), .src_imm(src_imm), .imm_out(imm_out),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rf_we(rf_we),
        .pc_load(pc_load), .pc_target(pc_target), .flag_z(flag_z), .flag_n(flag_n),
        .illegal(illegal), .halted(halted)
`ifdef SEQ_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mk(input int op, input int rd, input int rs1, input int low8);
        logic [18:0] v;
        v = {op[4:0], rd[2:0], rs1[2:0], low8[7:0]};
        return v;
    endfunction

    function automatic logic [18:0] mkbr(input int op, input int tgt);
        logic [18:0] v;
        v = {op[4:0], 3'd0, tgt[10:0]};
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_z = 0;
        m_n = 0;
        @(negedge clk);
    endtask

    // Drives one instruction and records outputs for cycles 1..5 after the accept edge.
    task automatic issue(input logic [18:0] ins, input logic z, input logic s);
        int w = 0;
        while (!instr_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            total_cnt++;
            $display("FAIL ready_timeout: instr_ready=%0b required 1", instr_ready);
            return;
        end
        instr = ins;
        instr_valid = 1'b1;
        alu_zero = 1'b0;
        alu_sign = 1'b0;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            obs_ready[c] = instr_ready;    obs_rf_we[c] = rf_we;     obs_pc_load[c] = pc_load;
            obs_illegal[c] = illegal;      obs_mode[c] = alu_mode;   obs_op[c] = alu_op;
            obs_src[c] = src_imm;          obs_imm[c] = imm_out;     obs_rs1[c] = rs1_addr;
            obs_rs2[c] = rs2_addr;         obs_rd[c] = rd_addr;      obs_target[c] = pc_target;
            obs_fz[c] = flag_z;            obs_fn[c] = flag_n;       obs_halted[c] = halted;
            if (c == 1) begin
                alu_zero = z;
                alu_sign = s;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total_cnt++;
        if ({alu_mode, alu_op, src_imm, imm_out, rs1_addr, rs2_addr, rd_addr, rf_we, pc_load,
             pc_target, flag_z, flag_n, illegal, halted, instr_ready} !== '0)
            $display("FAIL reset_outputs: some output nonzero (ready=%0b halted=%0b fz=%0b)", instr_ready, halted, flag_z);
        else pass_cnt++;
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", instr_ready); else pass_cnt++;
    endtask

    task automatic test_add();
        issue(mk(5'h01, 3, 1, 8'h40), 1'b0, 1'b0);
        total_cnt++;
        if ({obs_rs1[1], obs_rs2[1], obs_rd[1]} !== {3'd1, 3'd2, 3'd3})
            $display("FAIL add_addr: got rs1=%0d rs2=%0d rd=%0d want 1 2 3", obs_rs1[1], obs_rs2[1], obs_rd[1]);
        else pass_cnt++;
        total_cnt++;
        if ({obs_mode[2], obs_op[2], obs_src[2]} !== {1'b0, 4'h1, 1'b0})
            $display("FAIL add_ctrl: got mode=%0b op=%0h src=%0b want 0 1 0", obs_mode[2], obs_op[2], obs_src[2]);
        else pass_cnt++;
        total_cnt++;
        if ({obs_rf_we[2], obs_rf_we[3], obs_rf_we[4], obs_rd[3]} !== {1'b0, 1'b1, 1'b0, 3'd3})
            $display("FAIL add_we: got we2..4=%0b%0b%0b rd=%0d want 010 rd 3", obs_rf_we[2], obs_rf_we[3], obs_rf_we[4], obs_rd[3]);
        else pass_cnt++;
        total_cnt++;
        if ({obs_ready[3], obs_ready[4], obs_fz[4]} !== 3'b010)
            $display("FAIL add_ready_flag: got ready3=%0b ready4=%0b fz=%0b want 0 1 0", obs_ready[3], obs_ready[4], obs_fz[4]);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        issue(mk(5'h02, 2, 1, 8'h00), 1'b1, 1'b0);
        total_cnt++;
        if (obs_fz[4] !== 1'b1) $display("FAIL sub_flag_z: got %0b want 1", obs_fz[4]); else pass_cnt++;
        issue(mkbr(5'h19, 11'h155), 1'b0, 1'b0);
        total_cnt++;
        if ({obs_pc_load[1], obs_pc_load[2], obs_pc_load[3], obs_target[2]} !== {3'b010, 11'h155})
            $display("FAIL jz_taken: got load1..3=%0b%0b%0b tgt=%0h want 010 155", obs_pc_load[1], obs_pc_load[2], obs_pc_load[3], obs_target[2]);
        else pass_cnt++;
        total_cnt++;
        if (obs_ready[3] !== 1'b1) $display("FAIL jz_ready: got %0b want 1", obs_ready[3]); else pass_cnt++;
        issue(mkbr(5'h1A, 11'h155), 1'b0, 1'b0);
        total_cnt++;
        if ({obs_pc_load[2], obs_fz[3]} !== 2'b01)
            $display("FAIL jnz_not_taken: got load=%0b fz=%0b want 0 1", obs_pc_load[2], obs_fz[3]);
        else pass_cnt++;
    endtask

    task automatic test_addi_cmp();
        issue(mk(5'h10, 4, 5, 8'hF0), 1'b0, 1'b0);
        total_cnt++;
        if ({obs_mode[2], obs_op[2], obs_src[2], obs_imm[2]} !== {1'b0, 4'h1, 1'b1, 19'h7FFF0})
            $display("FAIL addi_ctrl: got mode=%0b op=%0h src=%0b imm=%0h want 0 1 1 7fff0", obs_mode[2], obs_op[2], obs_src[2], obs_imm[2]);
        else pass_cnt++;
        issue(mk(5'h05, 6, 1, 8'h20), 1'b0, 1'b1);
        total_cnt++;
        if ({obs_rf_we[1], obs_rf_we[2], obs_rf_we[3], obs_rf_we[4], obs_fn[4]} !== 5'b00001)
            $display("FAIL cmp_flags_only: got we=%0b%0b%0b%0b fn=%0b want 0000 1", obs_rf_we[1], obs_rf_we[2], obs_rf_we[3], obs_rf_we[4], obs_fn[4]);
        else pass_cnt++;
        issue(mkbr(5'h1B, 11'h2AA), 1'b0, 1'b0);
        total_cnt++;
        if ({obs_pc_load[2], obs_target[2]} !== {1'b1, 11'h2AA})
            $display("FAIL jn_taken: got load=%0b tgt=%0h want 1 2aa", obs_pc_load[2], obs_target[2]);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic fz0, fn0;
        fz0 = flag_z;
        fn0 = flag_n;
        issue(mk(5'h07, 1, 1, 8'h00), 1'b1, 1'b1);
        total_cnt++;
        if ({obs_illegal[1], obs_illegal[2], obs_ready[2]} !== 3'b101)
            $display("FAIL illegal_pulse: got ill1=%0b ill2=%0b ready2=%0b want 1 0 1", obs_illegal[1], obs_illegal[2], obs_ready[2]);
        else pass_cnt++;
        total_cnt++;
        if ({obs_rf_we[1], obs_rf_we[2], obs_rf_we[3], obs_fz[4], obs_fn[4]} !== {3'b000, fz0, fn0})
            $display("FAIL illegal_side_effect: got we=%0b%0b%0b fz=%0b fn=%0b want 000 %0b %0b", obs_rf_we[1], obs_rf_we[2], obs_rf_we[3], obs_fz[4], obs_fn[4], fz0, fn0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int op, rd, rs1, low8, tgt;
            bit z, s, is_alu, is_br, taken;
            logic [18:0] ins, exp_imm;
            op = $urandom_range(0, 31);
            if (op == 31) op = 0;
            rd = $urandom_range(0, 7);
            rs1 = $urandom_range(0, 7);
            low8 = $urandom_range(0, 255);
            z = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            ins = mk(op, rd, rs1, low8);
            tgt = int'(ins[10:0]);
            is_alu = (op >= 1 && op <= 5) || (op >= 8 && op <= 13) || op == 16;
            is_br = (op >= 24 && op <= 27);
            issue(ins, z, s);
            if (is_alu) begin
                exp_imm = (low8 >= 128) ? 19'(low8 + 524288 - 256) : 19'(low8);
                total_cnt++;
                if ({obs_mode[2], obs_op[2], obs_src[2], obs_imm[2]} !==
                    {(op >= 8 && op <= 13), (op == 16) ? 4'h1 : 4'(op % 16), (op == 16), exp_imm})
                    $display("FAIL rnd_alu_ctrl op=%0h: got mode=%0b op=%0h src=%0b imm=%0h", op, obs_mode[2], obs_op[2], obs_src[2], obs_imm[2]);
                else pass_cnt++;
                total_cnt++;
                if ({obs_rf_we[2], obs_rf_we[3], obs_rd[3], obs_ready[4]} !== {1'b0, (op != 5), 3'(rd), 1'b1})
                    $display("FAIL rnd_alu_wb op=%0h: got we=%0b%0b rd=%0d ready=%0b want rd %0d", op, obs_rf_we[2], obs_rf_we[3], obs_rd[3], obs_ready[4], rd);
                else pass_cnt++;
                m_z = z;
                m_n = s;
            end else if (is_br) begin
                taken = (op == 24) || (op == 25 && m_z) || (op == 26 && !m_z) || (op == 27 && m_n);
                total_cnt++;
                if ({obs_pc_load[2], obs_target[2], obs_ready[3], obs_rf_we[2]} !== {taken, 11'(tgt), 1'b1, 1'b0})
                    $display("FAIL rnd_branch op=%0h: got load=%0b tgt=%0h ready=%0b want %0b %0h", op, obs_pc_load[2], obs_target[2], obs_ready[3], taken, tgt);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if ({obs_illegal[1], obs_ready[2], obs_rf_we[2], obs_pc_load[2]} !== {(op != 0), 1'b1, 1'b0, 1'b0})
                    $display("FAIL rnd_nop_illegal op=%0h: got ill=%0b ready=%0b we=%0b load=%0b", op, obs_illegal[1], obs_ready[2], obs_rf_we[2], obs_pc_load[2]);
                else pass_cnt++;
            end
            total_cnt++;
            if ({obs_fz[4], obs_fn[4]} !== {m_z, m_n})
                $display("FAIL rnd_flags op=%0h: got z=%0b n=%0b want z=%0b n=%0b", op, obs_fz[4], obs_fn[4], m_z, m_n);
            else pass_cnt++;
        end
    endtask

    task automatic test_halt();
        int bad = 0;
        issue(mk(5'h1F, 0, 0, 8'h00), 1'b0, 1'b0);
        instr = mk(5'h01, 1, 1, 8'h00);
        instr_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (halted !== 1'b1 || instr_ready !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0 || obs_halted[2] !== 1'b1)
            $display("FAIL halt_hold: %0d bad cycles, halted=%0b ready=%0b want 1 0", bad, halted, instr_ready);
        else pass_cnt++;
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        total_cnt++;
        if ({alu_mode, alu_op, src_imm, imm_out, rs1_addr, rs2_addr, rd_addr, rf_we, pc_load,
             pc_target, flag_z, flag_n, illegal, halted, instr_ready} !== '0)
            $display("FAIL halt_reset: outputs nonzero halted=%0b ready=%0b", halted, instr_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr_ready, halted} !== 2'b10) $display("FAIL halt_recover: got ready=%0b halted=%0b want 1 0", instr_ready, halted);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_execute();
        int bad = 0;
        do_reset();
        @(negedge clk);
        instr = mk(5'h01, 3, 1, 8'h40);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        alu_zero = 1'b1;
        alu_sign = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 if (rf_we !== 1'b0 || flag_z !== 1'b0 || flag_n !== 1'b0 || pc_load !== 1'b0) bad++;
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rf_we !== 1'b0 || flag_z !== 1'b0 || flag_n !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL reset_in_execute: %0d cycles with we=%0b fz=%0b fn=%0b", bad, rf_we, flag_z, flag_n);
        else pass_cnt++;
        alu_zero = 1'b0;
        alu_sign = 1'b0;
    endtask

`ifdef SEQ_RETIRE_CNT_EN
    task automatic test_retire();
        do_reset();
        issue(mk(5'h01, 1, 1, 8'h00), 1'b0, 1'b0);
        issue(mk(5'h09, 2, 1, 8'h00), 1'b1, 1'b0);
        issue(mk(5'h05, 3, 1, 8'h00), 1'b0, 1'b0);
        issue(mk(5'h00, 0, 0, 8'h00), 1'b0, 1'b0);
        issue(mkbr(5'h18, 11'h010), 1'b0, 1'b0);
        issue(mkbr(5'h19, 11'h020), 1'b0, 1'b0);
        issue(mk(5'h07, 0, 0, 8'h00), 1'b0, 1'b0);
        total_cnt++;
        if (retire_cnt !== 16'd5) $display("FAIL retire_cnt: got %0d want 5", retire_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_addi_cmp();
        test_illegal();
        test_random();
        test_halt();
        test_reset_in_execute();
`ifdef SEQ_RETIRE_CNT_EN
        test_retire();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
